// File: rtl/lm75a_temp_monitor.sv
// LM75A temperature post-processor: captures the 11-bit reading, keeps a
// 2^AVG_LOG2-deep moving average, running min/max, a hysteretic alarm and a stale flag.
module lm75a_temp_monitor #(
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_valid,
  input  logic [15:0] data_in,
  input  logic [10:0] th_high,
  input  logic [10:0] th_low,
  input  logic        clr_minmax,
  output logic [10:0] temp_raw,
  output logic [10:0] temp_avg,
  output logic [10:0] temp_min,
  output logic [10:0] temp_max,
  output logic        temp_valid,
  output logic        alarm,
  output logic        stale
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 11 + AVG_LOG2;
  localparam int PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int CW    = $clog2(TIMEOUT + 1);

  logic signed [10:0]   raw_q, avg_q, min_q, max_q;
  logic signed [10:0]   avg_d, min_d, max_d;
  logic signed [10:0]   ring_q [DEPTH];
  logic signed [SW-1:0] sum_q, sum_d, new_ext, old_ext;
  logic [PW-1:0]        wp_q, wp_d;
  logic [1:0]           vld_pipe_q;
  logic                 first_q, alarm_q, alarm_d, seen_q;
  logic [CW-1:0]        cnt_q;

  // Stage 2 datapath; the first sample after reset preloads the whole window.
  always_comb begin
    new_ext = SW'(raw_q);
    old_ext = SW'(ring_q[wp_q]);
    sum_d   = first_q ? (new_ext <<< AVG_LOG2) : (sum_q + new_ext - old_ext);
    avg_d   = 11'(sum_d >>> AVG_LOG2);
    wp_d    = (DEPTH == 1) ? '0 : wp_q + PW'(1);

    alarm_d = alarm_q;
    if (avg_d >= $signed(th_high))    alarm_d = 1'b1;
    else if (avg_d < $signed(th_low)) alarm_d = 1'b0;

    // Clear presets first so a coincident update loads the new average into both.
    min_d = min_q;
    max_d = max_q;
    if (clr_minmax) begin
      min_d = 11'h3FF;
      max_d = 11'h400;
    end
    if (vld_pipe_q[0]) begin
      if (avg_d < min_d) min_d = avg_d;
      if (avg_d > max_d) max_d = avg_d;
    end
  end

  // Stage 1: capture and stale tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raw_q      <= '0;
      vld_pipe_q <= '0;
      cnt_q      <= '0;
      seen_q     <= 1'b0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], data_valid};
      if (data_valid) begin
        raw_q  <= data_in[15:5];
        cnt_q  <= '0;
        seen_q <= 1'b1;
      end else if (cnt_q != CW'(TIMEOUT)) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // Stage 2: averaging window, alarm and min/max.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      sum_q   <= '0;
      wp_q    <= '0;
      first_q <= 1'b1;
      avg_q   <= '0;
      alarm_q <= 1'b0;
      min_q   <= 11'h3FF;
      max_q   <= 11'h400;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
      if (vld_pipe_q[0]) begin
        if (first_q) begin
          for (int i = 0; i < DEPTH; i++) ring_q[i] <= raw_q;
          first_q <= 1'b0;
        end else begin
          ring_q[wp_q] <= raw_q;
          wp_q         <= wp_d;
        end
        sum_q   <= sum_d;
        avg_q   <= avg_d;
        alarm_q <= alarm_d;
      end
    end
  end

  assign temp_raw   = raw_q;
  assign temp_avg   = avg_q;
  assign temp_min   = min_q;
  assign temp_max   = max_q;
  assign temp_valid = vld_pipe_q[1];
  assign alarm      = alarm_q;
  assign stale      = ~seen_q | (cnt_q == CW'(TIMEOUT));

endmodule

// File: tb/tb_lm75a_temp_monitor.sv
// Randomized + directed bench: a window-average reference model feeds an expectation
// queue that a negedge monitor drains on every temp_valid pulse.
module tb_lm75a_temp_monitor;

  localparam int TO = 100;
  localparam int D  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        data_valid = 1'b0;
  logic [15:0] data_in = '0;
  logic [10:0] th_high = 11'h140;
  logic [10:0] th_low  = 11'h118;
  logic        clr_minmax = 1'b0;
  logic [10:0] temp_raw, temp_avg, temp_min, temp_max;
  logic        temp_valid, alarm, stale;

  lm75a_temp_monitor #(.AVG_LOG2(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data_in(data_in),
    .th_high(th_high), .th_low(th_low), .clr_minmax(clr_minmax),
    .temp_raw(temp_raw), .temp_avg(temp_avg), .temp_min(temp_min),
    .temp_max(temp_max), .temp_valid(temp_valid), .alarm(alarm), .stale(stale)
  );

  always #5 clk = ~clk;

  typedef struct { int avg; int mn; int mx; bit al; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // reference model state
  int hist[D];
  int wp_m, min_m, max_m, raw_m, cnt_m, pend_val;
  bit first_m, alarm_m, pend, seen_m;

  function automatic int s11(input logic [10:0] v);
    return int'($signed(v));
  endfunction

  function automatic int floor_div(input int s, input int d);
    return (s >= 0) ? s / d : -((-s + d - 1) / d);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) hist[i] = 0;
    wp_m = 0; first_m = 1; alarm_m = 0; min_m = 1023; max_m = -1024;
    raw_m = 0; cnt_m = 0; seen_m = 0; pend = 0;
  endtask

  // One clock edge of the reference: finish the sample captured last edge, then capture.
  task automatic model_edge(input bit dv, input logic [15:0] din, input bit clr);
    exp_t e;
    int sum, avg;
    if (pend) begin
      if (first_m) begin
        for (int i = 0; i < D; i++) hist[i] = pend_val;
        first_m = 0;
      end else begin
        hist[wp_m] = pend_val;
        wp_m = (wp_m + 1) % D;
      end
      sum = 0;
      for (int i = 0; i < D; i++) sum += hist[i];
      avg = floor_div(sum, D);
      if (avg >= s11(th_high)) alarm_m = 1;
      else if (avg < s11(th_low)) alarm_m = 0;
      if (clr) begin
        min_m = avg; max_m = avg;
      end else begin
        if (avg < min_m) min_m = avg;
        if (avg > max_m) max_m = avg;
      end
      e.avg = avg; e.mn = min_m; e.mx = max_m; e.al = alarm_m;
      exp_q.push_back(e);
    end else if (clr) begin
      min_m = 1023; max_m = -1024;
    end
    pend = dv;
    if (dv) begin
      pend_val = s11(din[15:5]);
      raw_m = pend_val;
      cnt_m = 0;
      seen_m = 1;
    end else if (cnt_m < TO) begin
      cnt_m++;
    end
  endtask

  task automatic step(input bit dv, input logic [15:0] din, input bit clr);
    data_valid = dv; data_in = din; clr_minmax = clr;
    @(posedge clk); #1;
    model_edge(dv, din, clr);
    data_valid = 1'b0; clr_minmax = 1'b0;
    chk("temp_raw", s11(temp_raw), raw_m);
    chk("stale", int'(stale), int'(!seen_m || cnt_m == TO));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("valid_in_reset", int'(temp_valid), 0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    chk("rst_raw", s11(temp_raw), 0);
    chk("rst_avg", s11(temp_avg), 0);
    chk("rst_min", int'(temp_min), 'h3FF);
    chk("rst_max", int'(temp_max), 'h400);
    chk("rst_alarm", int'(alarm), 0);
    chk("rst_stale", int'(stale), 1);
    chk("rst_valid", int'(temp_valid), 0);
  endtask

  // Monitor: every temp_valid pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (temp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: got pulse expected none (avg=%0d)", s11(temp_avg));
        end else begin
          e = exp_q.pop_front();
          chk("sb_avg", s11(temp_avg), e.avg);
          chk("sb_min", s11(temp_min), e.mn);
          chk("sb_max", s11(temp_max), e.mx);
          chk("sb_alarm", int'(alarm), int'(e.al));
        end
      end
    end
  end

  initial begin
    model_reset();
    do_reset(5);

    // first sample and averaging
    step(1'b1, 16'h1900, 1'b0);
    idle(2);
    chk("first_avg", int'(temp_avg), 'h0C8);
    chk("first_min", int'(temp_min), 'h0C8);
    chk("first_max", int'(temp_max), 'h0C8);
    for (int i = 0; i < 3; i++) step(1'b1, 16'h1900, 1'b0);
    step(1'b1, 16'hE700, 1'b0);
    idle(2);
    chk("avg_mix", int'(temp_avg), 'h064);
    chk("min_mix", int'(temp_min), 'h064);
    chk("max_mix", int'(temp_max), 'h0C8);
    for (int i = 0; i < 3; i++) step(1'b1, 16'hE700, 1'b0);
    idle(2);
    chk("avg_neg", int'(temp_avg), 'h738);

    // negative rounding toward -inf
    do_reset(5);
    step(1'b1, 16'hFFE0, 1'b0);
    step(1'b1, 16'h0000, 1'b0);
    idle(2);
    chk("avg_round", int'(temp_avg), 'h7FF);

    // hysteresis, then the th_low > th_high priority case
    do_reset(5);
    th_high = 11'h140; th_low = 11'h118;
    for (int i = 0; i < 4; i++) step(1'b1, 16'h2800, 1'b0);
    idle(2);
    chk("hyst_set", int'(alarm), 1);
    for (int i = 0; i < 4; i++) step(1'b1, 16'h2500, 1'b0);
    idle(2);
    chk("hyst_hold", int'(alarm), 1);
    for (int i = 0; i < 4; i++) step(1'b1, 16'h22E0, 1'b0);
    idle(2);
    chk("hyst_clr", int'(alarm), 0);
    th_low = 11'h150;
    for (int i = 0; i < 4; i++) step(1'b1, 16'h2800, 1'b0);
    idle(2);
    chk("prio_set", int'(alarm), 1);
    for (int i = 0; i < 4; i++) step(1'b1, 16'h22E0, 1'b0);
    idle(2);
    chk("prio_clr", int'(alarm), 0);
    th_low = 11'h118;

    // stale timeout (checked every cycle inside step)
    step(1'b1, 16'h1000, 1'b0);
    idle(TO + 5);
    step(1'b1, 16'h1100, 1'b0);
    idle(2);

    // back-to-back strobes
    step(1'b1, 16'h0A00, 1'b0);
    step(1'b1, 16'hF000, 1'b0);
    step(1'b1, 16'h3200, 1'b0);
    idle(3);

    // clr_minmax coincident with an update, and on its own
    step(1'b1, 16'h0320, 1'b0);
    step(1'b0, 16'h0000, 1'b1);
    idle(1);
    chk("clr_coinc_min", s11(temp_min), s11(temp_avg));
    chk("clr_coinc_max", s11(temp_max), s11(temp_avg));
    step(1'b0, 16'h0000, 1'b1);
    idle(1);
    chk("clr_only_min", int'(temp_min), 'h3FF);
    chk("clr_only_max", int'(temp_max), 'h400);

    // reset one edge after capture: the in-flight sample must vanish
    step(1'b1, 16'h4000, 1'b0);
    do_reset(3);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        th_high = 11'($urandom);
        th_low  = 11'($urandom);
      end
      step(($urandom_range(0, 2) != 0), 16'($urandom), ($urandom_range(0, 11) == 0));
    end
    idle(3);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
